rom_read_scheduler: RTL

- Shares the single 1024-entry subcarrier/preamble ROM between two burst requesters, e.g. the preamble generator (req 0) and the pilot inserter (req 1).
- Arbitrates between requests and generates sequential wrapping ROM addresses.
- Absorbs the ROM read latency with a credit-controlled output FIFO.
- Presents a valid/ready sample stream tagged with requester id and a last flag.
- Sits between the requesters, the ROM and the IFFT input mux.

---
 rtl/rom_read_scheduler.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/rom_read_scheduler.sv
// ============================================================================
// rom_read_scheduler: two-requester burst reader of a shared ROM with a
// credit-controlled output FIFO. Option ROM_SCHED_FIXED_PRIO_EN. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rom_read_scheduler #(
  parameter int AW         = 10,
  parameter int DW         = 16,
  parameter int ROM_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [AW:0]   req_len0,
  input  logic [AW:0]   req_len1,
  output logic [1:0]    req_ready,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_id,
  output logic          out_last,
  output logic          busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + ROM_LAT + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]         r_state;
  logic [AW-1:0]      r_addr;
  logic [AW:0]        r_remain;
  logic               r_id;

  logic [ROM_LAT-1:0] r_pv;
  logic [ROM_LAT-1:0] r_pid;
  logic [ROM_LAT-1:0] r_plast;

  logic [DW-1:0]      r_mem_data [FIFO_DEPTH];
  logic               r_mem_id   [FIFO_DEPTH];
  logic               r_mem_last [FIFO_DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;

  logic               w_grant;
  logic               w_gnt_id;
  logic [AW-1:0]      w_gnt_addr;
  logic [AW:0]        w_gnt_len;
  logic [CW-1:0]      w_inflight;
  logic               w_credit_ok;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;

  // Requests are only looked at in IDLE; reset masks the combinational accept.
  assign w_grant    = (r_state == S_IDLE) && (|req_valid) && !rst;
  assign w_gnt_addr = w_gnt_id ? req_addr1 : req_addr0;
  assign w_gnt_len  = w_gnt_id ? req_len1  : req_len0;

`ifdef ROM_SCHED_FIXED_PRIO_EN
  assign w_gnt_id = ~req_valid[0];
`else
  logic r_rr_ptr;

  // On a tie the pointer names the winner; it always moves to the loser.
  assign w_gnt_id = (&req_valid) ? r_rr_ptr : req_valid[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
    end else if (w_grant) begin
      r_rr_ptr <= ~w_gnt_id;
    end
  end
`endif

  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < ROM_LAT; k++) begin
      w_inflight = w_inflight + CW'(r_pv[k]);
    end
  end

  // Every issued read owns a FIFO slot until popped, so the FIFO never overflows.
  assign w_credit_ok = (r_count + w_inflight) < CW'(FIFO_DEPTH);
  assign w_issue     = (r_state == S_BURST) && w_credit_ok;
  assign w_push      = r_pv[ROM_LAT-1];
  assign w_pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_remain <= '0;
      r_id     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_addr   <= w_gnt_addr;
            r_remain <= w_gnt_len;
            r_id     <= w_gnt_id;
            if (w_gnt_len != '0) begin
              r_state <= S_BURST;
            end
          end
        end
        S_BURST: begin
          if (w_issue) begin
            r_addr   <= r_addr + AW'(1);
            r_remain <= r_remain - (AW+1)'(1);
            if (r_remain == (AW+1)'(1)) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pv    <= '0;
      r_pid   <= '0;
      r_plast <= '0;
    end else begin
      r_pv[0]    <= w_issue;
      r_pid[0]   <= r_id;
      r_plast[0] <= w_issue && (r_remain == (AW+1)'(1));
      for (int k = 1; k < ROM_LAT; k++) begin
        r_pv[k]    <= r_pv[k-1];
        r_pid[k]   <= r_pid[k-1];
        r_plast[k] <= r_plast[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= rom_data;
      r_mem_id[r_wr_ptr]   <= r_pid[ROM_LAT-1];
      r_mem_last[r_wr_ptr] <= r_plast[ROM_LAT-1];
    end
  end

  assign req_ready = w_grant ? (w_gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign rom_en    = w_issue;
  assign rom_addr  = w_issue ? r_addr : '0;
  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign out_id    = out_valid && r_mem_id[r_rd_ptr];
  assign out_last  = out_valid && r_mem_last[r_rd_ptr];
  assign busy      = (r_state != S_IDLE) || out_valid || (|r_pv);

endmodule

`default_nettype wire
